// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU MEM stage, the external loader/debug port and Data_Memory.
// The slave view belongs to the arbiter; the master view belongs to the surrounding system.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req_i;
    logic              cpu_we_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [DATA_W-1:0] cpu_wdata_i;
    logic [DATA_W-1:0] cpu_rdata_o;
    logic              cpu_stall_o;

    logic              ext_req_i;
    logic              ext_we_i;
    logic [ADDR_W-1:0] ext_addr_i;
    logic [DATA_W-1:0] ext_wdata_i;
    logic [DATA_W-1:0] ext_rdata_o;
    logic              ext_ack_o;

    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        input  ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i,
        input  mem_rdata_i,
        output cpu_rdata_o, cpu_stall_o, ext_rdata_o, ext_ack_o,
        output mem_addr_o, mem_we_o, mem_wdata_o
    );

    modport master (
        output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
        output ext_req_i, ext_we_i, ext_addr_i, ext_wdata_i,
        output mem_rdata_i,
        input  cpu_rdata_o, cpu_stall_o, ext_rdata_o, ext_ack_o,
        input  mem_addr_o, mem_we_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency data memory between the CPU MEM stage
// and an external loader port; stalls the CPU until its own access has completed.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 3
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    typedef enum logic {
        OWN_CPU,
        OWN_EXT
    } owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, last_q, grant_owner;
    logic              grant;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] ext_rdata_q;
    logic              ext_ack_q;
    logic              mem_we;
    logic              last_beat;

    assign last_beat = (state_q == S_ACCESS) && (cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        grant       = 1'b0;
        grant_owner = OWN_CPU;
        mem_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // On a tie the side that did not win last time gets the memory.
                if (bus.cpu_req_i && bus.ext_req_i) begin
                    grant       = 1'b1;
                    grant_owner = (last_q == OWN_EXT) ? OWN_CPU : OWN_EXT;
                end else if (bus.cpu_req_i) begin
                    grant       = 1'b1;
                    grant_owner = OWN_CPU;
                end else if (bus.ext_req_i) begin
                    grant       = 1'b1;
                    grant_owner = OWN_EXT;
                end
                if (grant) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // The counter starts at CNT_INIT, so that value marks the first access cycle.
                mem_we = we_q && (cnt_q == CNT_INIT);
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            owner_q     <= OWN_CPU;
            last_q      <= OWN_EXT;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
            ext_ack_q   <= 1'b0;
        end else begin
            if (grant) begin
                owner_q <= grant_owner;
                last_q  <= grant_owner;
                cnt_q   <= CNT_INIT;
                if (grant_owner == OWN_CPU) begin
                    we_q    <= bus.cpu_we_i;
                    addr_q  <= bus.cpu_addr_i;
                    wdata_q <= bus.cpu_wdata_i;
                end else begin
                    we_q    <= bus.ext_we_i;
                    addr_q  <= bus.ext_addr_i;
                    wdata_q <= bus.ext_wdata_i;
                end
            end else if ((state_q == S_ACCESS) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (last_beat && !we_q) begin
                if (owner_q == OWN_CPU) begin
                    cpu_rdata_q <= bus.mem_rdata_i;
                end else begin
                    ext_rdata_q <= bus.mem_rdata_i;
                end
            end

            // Registered so the pulse coincides exactly with the DONE cycle.
            ext_ack_q <= last_beat && (owner_q == OWN_EXT);
        end
    end

    assign bus.cpu_stall_o = bus.cpu_req_i && !((state_q == S_DONE) && (owner_q == OWN_CPU));
    assign bus.cpu_rdata_o = cpu_rdata_q;
    assign bus.ext_rdata_o = ext_rdata_q;
    assign bus.ext_ack_o   = ext_ack_q;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_we_o    = mem_we;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios on MEM_LAT=3 and MEM_LAT=1 instances plus a
// randomized run checked against a transaction-level scheduling model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LAT0 = 3;

    logic clk_i = 1'b0;
    logic rst_n_i;
    logic mem_load;
    int   mem_seed;
    int   tests_run = 0;
    int   fails = 0;

    logic [DW-1:0] tb_mem0 [16];
    logic [DW-1:0] tb_mem1 [16];

    always #5 clk_i = ~clk_i;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT0)) dut0 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus0));
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .bus(bus1));

    function automatic logic [31:0] init_word(int seed, int i);
        if (seed == 0 && i == 4) return 32'hDEADBEEF;
        return (32'(i) * 32'h1111_1111) ^ 32'hA5A5_0000 ^ 32'(seed);
    endfunction

    // Combinational-read, synchronous-write data memories.
    assign bus0.mem_rdata_i = tb_mem0[bus0.mem_addr_o[5:2]];
    assign bus1.mem_rdata_i = tb_mem1[bus1.mem_addr_o[5:2]];

    always @(posedge clk_i) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) begin
                tb_mem0[i] <= init_word(mem_seed, i);
                tb_mem1[i] <= init_word(mem_seed, i);
            end
        end else begin
            if (bus0.mem_we_o) tb_mem0[bus0.mem_addr_o[5:2]] <= bus0.mem_wdata_o;
            if (bus1.mem_we_o) tb_mem1[bus1.mem_addr_o[5:2]] <= bus1.mem_wdata_o;
        end
    end

    task automatic idle_inputs();
        bus0.cpu_req_i = 0; bus0.cpu_we_i = 0; bus0.cpu_addr_i = '0; bus0.cpu_wdata_i = '0;
        bus0.ext_req_i = 0; bus0.ext_we_i = 0; bus0.ext_addr_i = '0; bus0.ext_wdata_i = '0;
        bus1.cpu_req_i = 0; bus1.cpu_we_i = 0; bus1.cpu_addr_i = '0; bus1.cpu_wdata_i = '0;
        bus1.ext_req_i = 0; bus1.ext_we_i = 0; bus1.ext_addr_i = '0; bus1.ext_wdata_i = '0;
    endtask

    task automatic do_reset(int seed);
        rst_n_i = 1'b0;
        idle_inputs();
        mem_seed = seed;
        mem_load = 1'b1;
        @(posedge clk_i); #1;
        mem_load = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(0);
        @(negedge clk_i);
        tests_run++; if (bus0.cpu_rdata_o !== 32'h0) begin fails++; $display("FAIL rst_cpu_rdata got %h exp 0", bus0.cpu_rdata_o); end
        tests_run++; if (bus0.ext_rdata_o !== 32'h0) begin fails++; $display("FAIL rst_ext_rdata got %h exp 0", bus0.ext_rdata_o); end
        tests_run++; if (bus0.ext_ack_o !== 1'b0) begin fails++; $display("FAIL rst_ext_ack got %b exp 0", bus0.ext_ack_o); end
        tests_run++; if (bus0.mem_we_o !== 1'b0) begin fails++; $display("FAIL rst_mem_we got %b exp 0", bus0.mem_we_o); end
        @(posedge clk_i); #1;
        // CPU load so that cpu_rdata is non-zero before the abort
        bus0.cpu_req_i = 1; bus0.cpu_we_i = 0; bus0.cpu_addr_i = 32'h10;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk_i); #1;
        end
        tests_run++; if (bus0.cpu_rdata_o !== 32'hDEADBEEF) begin fails++; $display("FAIL rst_pre_load got %h exp deadbeef", bus0.cpu_rdata_o); end
        bus0.cpu_req_i = 0;
        bus0.ext_req_i = 1; bus0.ext_we_i = 1; bus0.ext_addr_i = 32'h24; bus0.ext_wdata_i = 32'h77;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        tests_run++; if (bus0.mem_we_o !== 1'b1) begin fails++; $display("FAIL rst_store_pulse got %b exp 1", bus0.mem_we_o); end
        rst_n_i = 1'b0;
        bus0.ext_req_i = 0;
        #1;
        tests_run++; if (bus0.mem_we_o !== 1'b0) begin fails++; $display("FAIL rst_we_async got %b exp 0", bus0.mem_we_o); end
        tests_run++; if (bus0.cpu_rdata_o !== 32'h0) begin fails++; $display("FAIL rst_rdata_async got %h exp 0", bus0.cpu_rdata_o); end
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            tests_run++;
            if (bus0.ext_ack_o !== 1'b0 || bus0.mem_we_o !== 1'b0) begin
                fails++; $display("FAIL rst_abort c=%0d ack %b we %b exp 0 0", c, bus0.ext_ack_o, bus0.mem_we_o);
            end
            @(posedge clk_i); #1;
        end
        tests_run++; if (tb_mem0[9] !== init_word(0, 9)) begin fails++; $display("FAIL rst_no_write got %h exp %h", tb_mem0[9], init_word(0, 9)); end
    endtask

    task automatic test_cpu_load();
        bus0.cpu_req_i = 1; bus0.cpu_we_i = 0; bus0.cpu_addr_i = 32'h10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            tests_run++; if (bus0.cpu_stall_o !== (c < 4)) begin fails++; $display("FAIL load_stall c=%0d got %b exp %b", c, bus0.cpu_stall_o, (c < 4)); end
            tests_run++; if (bus0.mem_we_o !== 1'b0) begin fails++; $display("FAIL load_we c=%0d got %b exp 0", c, bus0.mem_we_o); end
            if (c == 4) begin
                tests_run++; if (bus0.cpu_rdata_o !== 32'hDEADBEEF) begin fails++; $display("FAIL load_rdata got %h exp deadbeef", bus0.cpu_rdata_o); end
            end
            @(posedge clk_i); #1;
        end
        bus0.cpu_req_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_cpu_store();
        bus0.cpu_req_i = 1; bus0.cpu_we_i = 1; bus0.cpu_addr_i = 32'h20; bus0.cpu_wdata_i = 32'h5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            tests_run++; if (bus0.mem_we_o !== (c == 1)) begin fails++; $display("FAIL store_we c=%0d got %b exp %b", c, bus0.mem_we_o, (c == 1)); end
            if (c == 1) begin
                tests_run++; if (bus0.mem_addr_o !== 32'h20) begin fails++; $display("FAIL store_addr got %h exp 20", bus0.mem_addr_o); end
                tests_run++; if (bus0.mem_wdata_o !== 32'h5) begin fails++; $display("FAIL store_wdata got %h exp 5", bus0.mem_wdata_o); end
            end
            if (c == 4) begin
                tests_run++; if (bus0.cpu_stall_o !== 1'b0) begin fails++; $display("FAIL store_release got %b exp 0", bus0.cpu_stall_o); end
                tests_run++; if (bus0.cpu_rdata_o !== 32'hDEADBEEF) begin fails++; $display("FAIL store_rdata_kept got %h exp deadbeef", bus0.cpu_rdata_o); end
            end
            @(posedge clk_i); #1;
        end
        bus0.cpu_req_i = 0;
        tests_run++; if (tb_mem0[8] !== 32'h5) begin fails++; $display("FAIL store_mem got %h exp 5", tb_mem0[8]); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        do_reset(0);
        bus0.cpu_req_i = 1; bus0.cpu_we_i = 0; bus0.cpu_addr_i = 32'h30;
        bus0.ext_req_i = 1; bus0.ext_we_i = 0; bus0.ext_addr_i = 32'h34;
        for (int c = 0; c < 15; c++) begin
            if (c == 10) bus0.ext_req_i = 0;
            @(negedge clk_i);
            tests_run++; if (bus0.ext_ack_o !== (c == 9)) begin fails++; $display("FAIL rr_ack c=%0d got %b exp %b", c, bus0.ext_ack_o, (c == 9)); end
            tests_run++; if (bus0.cpu_stall_o !== !(c == 4 || c == 14)) begin fails++; $display("FAIL rr_stall c=%0d got %b", c, bus0.cpu_stall_o); end
            if (c == 1 || c == 6 || c == 11) begin
                exp_addr = (c == 6) ? 32'h34 : 32'h30;
                tests_run++; if (bus0.mem_addr_o !== exp_addr) begin fails++; $display("FAIL rr_grant c=%0d got %h exp %h", c, bus0.mem_addr_o, exp_addr); end
            end
            if (c == 9) begin
                tests_run++; if (bus0.ext_rdata_o !== init_word(0, 13)) begin fails++; $display("FAIL rr_ext_rdata got %h exp %h", bus0.ext_rdata_o, init_word(0, 13)); end
            end
            @(posedge clk_i); #1;
        end
        bus0.cpu_req_i = 0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_ext_after_cpu();
        bus0.cpu_req_i = 1; bus0.cpu_we_i = 0; bus0.cpu_addr_i = 32'h10;
        for (int c = 0; c < 12; c++) begin
            if (c == 1) begin bus0.ext_req_i = 1; bus0.ext_we_i = 0; bus0.ext_addr_i = 32'h3C; end
            if (c == 5) bus0.cpu_req_i = 0;
            if (c == 10) bus0.ext_req_i = 0;
            @(negedge clk_i);
            tests_run++; if (bus0.ext_ack_o !== (c == 9)) begin fails++; $display("FAIL ext_ack c=%0d got %b exp %b", c, bus0.ext_ack_o, (c == 9)); end
            tests_run++; if (bus0.cpu_stall_o !== (c < 4)) begin fails++; $display("FAIL ext_cpu_stall c=%0d got %b exp %b", c, bus0.cpu_stall_o, (c < 4)); end
            if (c == 6) begin
                tests_run++; if (bus0.mem_addr_o !== 32'h3C) begin fails++; $display("FAIL ext_grant got %h exp 3c", bus0.mem_addr_o); end
            end
            if (c == 9) begin
                tests_run++; if (bus0.ext_rdata_o !== init_word(0, 15)) begin fails++; $display("FAIL ext_rdata got %h exp %h", bus0.ext_rdata_o, init_word(0, 15)); end
            end
            @(posedge clk_i); #1;
        end
    endtask

    task automatic test_mem_lat1();
        bus1.cpu_req_i = 1; bus1.cpu_we_i = 0;
        for (int c = 0; c < 9; c++) begin
            if (c % 3 == 0) bus1.cpu_addr_i = 32'(4 * (c / 3));
            @(negedge clk_i);
            tests_run++; if (bus1.cpu_stall_o !== !(c % 3 == 2)) begin fails++; $display("FAIL lat1_stall c=%0d got %b", c, bus1.cpu_stall_o); end
            tests_run++; if (bus1.mem_we_o !== 1'b0) begin fails++; $display("FAIL lat1_we c=%0d got %b exp 0", c, bus1.mem_we_o); end
            if (c % 3 == 2) begin
                tests_run++; if (bus1.cpu_rdata_o !== init_word(0, c / 3)) begin fails++; $display("FAIL lat1_rdata c=%0d got %h exp %h", c, bus1.cpu_rdata_o, init_word(0, c / 3)); end
            end
            @(posedge clk_i); #1;
        end
        bus1.cpu_req_i = 0;
        @(posedge clk_i); #1;
    endtask

    // Transaction-level model: the memory serves one request at a time, each occupying
    // LAT0+2 cycles from the IDLE cycle it is seen in; ties go to whoever did not win last.
    task automatic test_random();
        logic [31:0] ref_mem [16];
        int free_at = 0, svc_start = -10, svc_done = -10;
        bit svc_ext = 0, svc_we = 0, last_ext = 1;
        logic [31:0] svc_addr = 0, svc_wdata = 0, svc_rexp = 0;
        logic [31:0] exp_cpu_rd = 0, exp_ext_rd = 0;
        bit c_busy = 0, c_drop = 0, c_gnt = 0, e_busy = 0, e_drop = 0, e_gnt = 0;
        bit c_we = 0, e_we = 0, pc, pe, exp_we, exp_ack, exp_stall;
        logic [31:0] c_addr = 0, c_wd = 0, e_addr = 0, e_wd = 0;
        do_reset(7);
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(7, i);
        for (int k = 0; k < 400; k++) begin
            pc = c_busy && !c_drop;
            pe = e_busy && !e_drop;
            bus0.cpu_req_i = pc; bus0.cpu_we_i = c_we; bus0.cpu_addr_i = c_addr; bus0.cpu_wdata_i = c_wd;
            bus0.ext_req_i = pe; bus0.ext_we_i = e_we; bus0.ext_addr_i = e_addr; bus0.ext_wdata_i = e_wd;
            if (k >= free_at && (pc || pe)) begin
                svc_ext = pe && (!pc || !last_ext);
                last_ext = svc_ext;
                svc_we = svc_ext ? e_we : c_we;
                svc_addr = svc_ext ? e_addr : c_addr;
                svc_wdata = svc_ext ? e_wd : c_wd;
                svc_start = k;
                svc_done = k + LAT0 + 1;
                free_at = k + LAT0 + 2;
                if (svc_we) ref_mem[svc_addr[5:2]] = svc_wdata;
                else svc_rexp = ref_mem[svc_addr[5:2]];
                if (svc_ext) e_gnt = 1; else c_gnt = 1;
            end
            @(negedge clk_i);
            exp_we = svc_we && (k == svc_start + 1);
            exp_ack = (k == svc_done) && svc_ext;
            exp_stall = pc && !((k == svc_done) && !svc_ext);
            if (k == svc_done && !svc_we) begin
                if (svc_ext) exp_ext_rd = svc_rexp; else exp_cpu_rd = svc_rexp;
            end
            tests_run++; if (bus0.mem_we_o !== exp_we) begin fails++; $display("FAIL rnd_we k=%0d got %b exp %b", k, bus0.mem_we_o, exp_we); end
            if (exp_we) begin
                tests_run++;
                if (bus0.mem_addr_o !== svc_addr || bus0.mem_wdata_o !== svc_wdata) begin
                    fails++; $display("FAIL rnd_wr k=%0d got %h/%h exp %h/%h", k, bus0.mem_addr_o, bus0.mem_wdata_o, svc_addr, svc_wdata);
                end
            end
            tests_run++; if (bus0.ext_ack_o !== exp_ack) begin fails++; $display("FAIL rnd_ack k=%0d got %b exp %b", k, bus0.ext_ack_o, exp_ack); end
            tests_run++; if (bus0.cpu_stall_o !== exp_stall) begin fails++; $display("FAIL rnd_stall k=%0d got %b exp %b", k, bus0.cpu_stall_o, exp_stall); end
            tests_run++; if (bus0.cpu_rdata_o !== exp_cpu_rd) begin fails++; $display("FAIL rnd_cpu_rd k=%0d got %h exp %h", k, bus0.cpu_rdata_o, exp_cpu_rd); end
            tests_run++; if (bus0.ext_rdata_o !== exp_ext_rd) begin fails++; $display("FAIL rnd_ext_rd k=%0d got %h exp %h", k, bus0.ext_rdata_o, exp_ext_rd); end
            if (k == svc_done) begin
                if (svc_ext) begin e_busy = 0; e_drop = 0; e_gnt = 0; end
                else begin c_busy = 0; c_drop = 0; c_gnt = 0; end
            end
            if (c_gnt && $urandom_range(15) == 0) c_drop = 1;
            if (e_gnt && $urandom_range(15) == 0) e_drop = 1;
            if (!c_busy && $urandom_range(1) == 1) begin
                c_busy = 1; c_we = 1'($urandom_range(1));
                c_addr = {26'h0, 4'($urandom_range(15)), 2'b00}; c_wd = $urandom;
            end
            if (!e_busy && $urandom_range(2) == 0) begin
                e_busy = 1; e_we = 1'($urandom_range(1));
                e_addr = {26'h0, 4'($urandom_range(15)), 2'b00}; e_wd = $urandom;
            end
            @(posedge clk_i); #1;
        end
        idle_inputs();
        @(posedge clk_i); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_load = 1'b0;
        mem_seed = 0;
        test_reset();
        test_cpu_load();
        test_cpu_store();
        test_round_robin();
        test_ext_after_cpu();
        test_mem_lat1();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
